lsu_op_sequencer: RTL

LSU_OP_SEQUENCER -- requirements
Module: lsu_op_sequencer

---
 rtl/lsu_op_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_op_sequencer.sv
// lsu_op_sequencer: splits a decoded LSU op into per-beat memory requests.
// Ports: op_* offer/accept, mem_req_*/mem_rsp_valid memory side, done_* completion.
// Option: define LSU_SEQ_TIMEOUT_EN to enable a stall watchdog (TIMEOUT_CYCLES).
module lsu_op_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        op_rd,
    input  logic        op_wr,
    input  logic [5:0]  op_cnt,
    input  logic [1:0]  op_depth,
    input  logic        op_gpr,
    input  logic [31:0] op_base_addr,
    input  logic [5:0]  op_wfid,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_rd,
    output logic        mem_req_wr,
    output logic [31:0] mem_req_addr,
    output logic [5:0]  mem_req_lane,
    output logic [1:0]  mem_req_slot,
    output logic        mem_req_gpr,
    input  logic        mem_rsp_valid,
    output logic        done_valid,
    output logic [5:0]  done_wfid,
    output logic        done_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} state_t;

    state_t      state;
    logic        rd_q;
    logic        wr_q;
    logic        gpr_q;
    logic [5:0]  cnt_q;
    logic [1:0]  depth_q;
    logic [5:0]  lane_q;
    logic [1:0]  slot_q;
    logic [5:0]  wfid_q;
    logic [31:0] addr_q;
    logic [8:0]  total_q;
    logic [8:0]  rsp_cnt;
    logic        extra_q;
    logic        err_q;

    logic accept;
    logic hs;
    logic last;
    logic active;
    logic rsp_take;
    logic extra_now;
    logic stall_hit;
    logic [8:0] total_d;

    assign accept    = op_valid && (state == IDLE);
    assign hs        = (state == ISSUE) && mem_req_ready;
    assign last      = (lane_q == cnt_q) && (slot_q == depth_q);
    assign active    = (state == ISSUE) || (state == WAIT_RSP);
    assign rsp_take  = mem_rsp_valid && active && (rsp_cnt != total_q);
    assign extra_now = mem_rsp_valid && !rsp_take;
    assign total_d   = ({3'b0, op_cnt} + 9'd1) * ({7'b0, op_depth} + 9'd1);

`ifdef LSU_SEQ_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
    logic [SW-1:0] stall_q;

    // Fires on the edge where the idle count would reach the limit.
    assign stall_hit = active && !hs && !mem_rsp_valid &&
                       ((stall_q + SW'(1)) == SW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (accept || hs || mem_rsp_valid || !active) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_q + SW'(1);
        end
    end
`else
    assign stall_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            gpr_q   <= 1'b0;
            cnt_q   <= '0;
            depth_q <= '0;
            lane_q  <= '0;
            slot_q  <= '0;
            wfid_q  <= '0;
            addr_q  <= '0;
            total_q <= '0;
            rsp_cnt <= '0;
            extra_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                extra_q <= 1'b0;
                rsp_cnt <= '0;
            end else begin
                if (extra_now) extra_q <= 1'b1;
                if (rsp_take)  rsp_cnt <= rsp_cnt + 9'd1;
            end
            unique case (state)
                IDLE: begin
                    if (op_valid) begin
                        rd_q    <= op_rd;
                        wr_q    <= op_wr;
                        gpr_q   <= op_gpr;
                        cnt_q   <= op_cnt;
                        depth_q <= op_depth;
                        wfid_q  <= op_wfid;
                        addr_q  <= op_base_addr;
                        total_q <= total_d;
                        lane_q  <= '0;
                        slot_q  <= '0;
                        if (op_rd ^ op_wr) begin
                            state <= ISSUE;
                            err_q <= 1'b0;
                        end else begin
                            state <= DONE;
                            err_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (stall_hit) begin
                        state <= DONE;
                        err_q <= 1'b1;
                    end else if (hs) begin
                        // Beats are issued in order, so the address is a running sum.
                        addr_q <= addr_q + 32'd4;
                        if (lane_q == cnt_q) begin
                            lane_q <= '0;
                            slot_q <= slot_q + 2'd1;
                        end else begin
                            lane_q <= lane_q + 6'd1;
                        end
                        if (last) begin
                            if (rd_q) begin
                                state <= WAIT_RSP;
                            end else begin
                                state <= DONE;
                                err_q <= extra_q || extra_now;
                            end
                        end
                    end
                end
                WAIT_RSP: begin
                    if (stall_hit) begin
                        state <= DONE;
                        err_q <= 1'b1;
                    end else if (rsp_cnt == total_q) begin
                        state <= DONE;
                        err_q <= extra_q || extra_now;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign op_ready      = (state == IDLE);
    assign busy          = (state != IDLE);
    assign mem_req_valid = (state == ISSUE);
    assign mem_req_rd    = (state == ISSUE) && rd_q;
    assign mem_req_wr    = (state == ISSUE) && wr_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_lane  = lane_q;
    assign mem_req_slot  = slot_q;
    assign mem_req_gpr   = gpr_q;
    assign done_valid    = (state == DONE);
    assign done_wfid     = wfid_q;
    assign done_err      = (state == DONE) && err_q;

endmodule
